// File: rtl/write_arb_pkg.sv
// Shared types and limits for the write-port arbiter.
// Holds the arbiter state encoding and the legal client-count range.
package write_arb_pkg;

    localparam int MIN_CLIENTS = 2;
    localparam int MAX_CLIENTS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/write_port_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot winner from a request vector.
// Ports: req_i (requests), last_i (index of last owner), win_o (one-hot, zero if none).
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     win_o
);

    // Walk from the farthest candidate to the nearest so the client right
    // after last_i overwrites any lower-priority hit.
    always_comb begin
        win_o = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(last_i) + k) % N]) begin
                win_o = '0;
                win_o[(int'(last_i) + k) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/write_port_arbiter.sv
// Shares one RAM-emulator write port among NUM_CLIENTS writers.
// Each grant covers one address beat then one data beat, never interleaved.
// Ports: clk/reset (sync, active-high); c_* per-client request side
// (write_en, mode, addr, data, accepted); write_en/write_mode_data/w_addr/
// w_data/write_accepted downstream side; grant one-hot owner; proto_error sticky.
module write_port_arbiter
    import write_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BITS   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CLIENTS-1:0]           c_write_en,
    input  logic [NUM_CLIENTS-1:0]           c_write_mode_data,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0] c_w_addr,
    input  logic [NUM_CLIENTS*DATA_BITS-1:0] c_w_data,
    output logic [NUM_CLIENTS-1:0]           c_write_accepted,
    output logic                             write_en,
    output logic                             write_mode_data,
    output logic [ADDR_BITS-1:0]             w_addr,
    output logic [DATA_BITS-1:0]             w_data,
    input  logic                             write_accepted,
    output logic [NUM_CLIENTS-1:0]           grant,
    output logic                             proto_error
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    if (NUM_CLIENTS < MIN_CLIENTS || NUM_CLIENTS > MAX_CLIENTS) begin : g_bad_n
        $error("write_port_arbiter: NUM_CLIENTS out of range");
    end

    arb_state_e             state_q;
    logic [NUM_CLIENTS-1:0] grant_q;
    logic [IDX_W-1:0]       last_q;
    logic                   perr_q;

    logic [NUM_CLIENTS-1:0] req;
    logic [NUM_CLIENTS-1:0] win;
    logic [IDX_W-1:0]       owner_idx;
    logic [IDX_W-1:0]       pick_last;
    logic                   g_en;
    logic                   g_md;
    logic                   active;
    logic                   beat_ok;
    logic                   err;

    assign req = c_write_en & ~c_write_mode_data;

    // Mux the granted client onto the downstream port; grant_q is zero in IDLE.
    always_comb begin
        w_addr    = '0;
        w_data    = '0;
        g_en      = 1'b0;
        g_md      = 1'b0;
        owner_idx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_q[i]) begin
                w_addr    = c_w_addr[i*ADDR_BITS +: ADDR_BITS];
                w_data    = c_w_data[i*DATA_BITS +: DATA_BITS];
                g_en      = c_write_en[i];
                g_md      = c_write_mode_data[i];
                owner_idx = IDX_W'(i);
            end
        end
    end

    assign active          = (state_q != IDLE);
    assign write_en        = active & g_en;
    assign write_mode_data = (state_q == DATA);
    assign beat_ok         = write_accepted & write_en;
    assign grant           = grant_q;
    assign proto_error     = perr_q;

    assign c_write_accepted =
        (write_accepted && active && !reset) ? grant_q : '0;

    // Completing a data beat re-arbitrates in the same cycle, so the picker
    // must already see the current owner as the last one.
    assign pick_last = (state_q == DATA) ? owner_idx : last_q;

    // An accept while write_en is low covers the IDLE case as well.
    assign err = (active && g_en && (g_md != (state_q == DATA)))
               || (write_accepted && !write_en);

    rr_pick #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (req),
        .last_i (pick_last),
        .win_o  (win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_CLIENTS - 1);
            perr_q  <= 1'b0;
        end else begin
            if (err) begin
                perr_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q <= win;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (beat_ok) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (beat_ok) begin
                        last_q <= owner_idx;
                        if (|req) begin
                            grant_q <= win;
                            state_q <= ADDR;
                        end else begin
                            grant_q <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/write_port_arbiter.md
WRITE_PORT_ARBITER -- requirements
Module: write_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 2, number of writers sharing one RAM-emulator write port (legal 2..4).
REQ-002 SHALL have parameter ADDR_BITS, default 16, write address width.
REQ-003 SHALL have parameter DATA_BITS, default 16, write data width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port c_write_en  input  NUM_CLIENTS  per-client write request valid.
REQ-007 SHALL have port c_write_mode_data  input  NUM_CLIENTS  per-client phase: 0 address, 1 data.
REQ-008 SHALL have port c_w_addr  input  NUM_CLIENTS*ADDR_BITS  per-client address; client i in bits [i*ADDR_BITS +: ADDR_BITS].
REQ-009 SHALL have port c_w_data  input  NUM_CLIENTS*DATA_BITS  per-client data, packed the same way.
REQ-010 SHALL have port c_write_accepted  output  NUM_CLIENTS  per-client accept, one-hot or zero.
REQ-011 SHALL have port write_en  output  1  downstream write valid.
REQ-012 SHALL have port write_mode_data  output  1  downstream phase: 0 address, 1 data.
REQ-013 SHALL have port w_addr  output  ADDR_BITS  downstream address.
REQ-014 SHALL have port w_data  output  DATA_BITS  downstream data.
REQ-015 SHALL have port write_accepted  input  1  downstream accept of current beat.
REQ-016 SHALL have port grant  output  NUM_CLIENTS  one-hot current owner, zero when idle.
REQ-017 SHALL have port proto_error  output  1  sticky protocol-violation flag.

Function
REQ-018 Request of client i SHALL be c_write_en[i] && !c_write_mode_data[i].
REQ-019 FSM SHALL have states IDLE, ADDR, DATA; one address beat plus one data beat form an atomic transaction never interleaved with another client.
REQ-020 In IDLE with any request, SHALL register the round-robin winner into grant and enter ADDR next cycle; no request -> stay IDLE.
REQ-021 Round-robin SHALL search from the client after the last completed owner, wrapping NUM_CLIENTS-1 -> 0.
REQ-022 In ADDR and DATA, w_addr/w_data/write_en SHALL combinationally mirror the granted client's signals.
REQ-023 write_mode_data SHALL be 0 in ADDR, 1 in DATA, and 0 in IDLE.
REQ-024 write_en SHALL be 0 in IDLE.
REQ-025 c_write_accepted[i] SHALL equal write_accepted && grant[i] && state != IDLE, combinationally, same cycle.
REQ-026 ADDR + write_accepted SHALL -> DATA next cycle.
REQ-027 DATA + write_accepted SHALL record the owner as last, then re-arbitrate in the same cycle: any request (including the same client, subject to REQ-021) -> ADDR with new grant; none -> IDLE.
REQ-028 Back-to-back transactions SHALL therefore have zero idle cycles between a data accept and the next address beat.
REQ-029 proto_error SHALL set on: granted client's c_write_mode_data mismatching state while its c_write_en is high; write_accepted high in IDLE; write_accepted while write_en low.
REQ-030 Illegal write_accepted SHALL not change the state or grant.
REQ-031 Data-phase requests from non-granted clients SHALL be ignored without error.
REQ-032 A granted client dropping c_write_en mid-transaction SHALL keep the grant; write_en follows it low.

Reset
REQ-033 Reset SHALL force state IDLE, grant 0, last owner NUM_CLIENTS-1 (so client 0 wins first), proto_error 0, and outputs write_en=0, write_mode_data=0, c_write_accepted=0.
REQ-034 Reset mid-transaction SHALL abandon it with no accept issued in the reset cycle.

Structure
REQ-035 Package write_arb_pkg SHALL hold the state enum (IDLE, ADDR, DATA) and the NUM_CLIENTS legality limits.
REQ-036 Sub-module rr_pick SHALL implement the combinational round-robin picker (request vector plus last owner -> one-hot winner).

Verification
REQ-037 Client 0 alone writes addr 0x1234 and data 0xABCD, with immediate accept -> grant 01 one cycle after request, downstream beats 0x1234 (mode 0) then 0xABCD (mode 1), then IDLE.
REQ-038 Both clients request continuously, always accepted -> transactions alternate 0,1,0,1 with no idle cycle between them.
REQ-039 Client 1 granted; client 0 requests during DATA; downstream stalls 3 cycles -> no client-0 beat appears until client 1's data accept; client 0's address beat follows on the next cycle.
REQ-040 write_accepted pulsed in IDLE -> proto_error=1 and stays 1; state remains IDLE.
REQ-041 Reset asserted while in DATA -> next cycle grant=0, write_en=0; after release, client 0 wins a simultaneous request.
